// File: rtl/reg8file_reader_if.sv
// Handshake/bus bundle between reg8file_reader and its register file / byte consumer.
// REG8FILE_READER_PARITY_EN adds the parity signal to the bundle.
interface reg8file_reader_if #(
   parameter int NREG   = 8,
   parameter int RSEL_W = 3
);
   logic              start;
   logic [RSEL_W-1:0] rsel;
   logic              q;
   logic [NREG-1:0]   data;
   logic              valid;
   logic              ready;
   logic              busy;
`ifdef REG8FILE_READER_PARITY_EN
   logic              parity;

   modport master (input start, q, ready, output rsel, data, valid, busy, parity);
   modport slave  (output start, q, ready, input rsel, data, valid, busy, parity);
`else
   modport master (input start, q, ready, output rsel, data, valid, busy);
   modport slave  (output start, q, ready, input rsel, data, valid, busy);
`endif
endinterface

// File: rtl/reg8file_reader.sv
// Scans a 1-bit-wide register file entry by entry and presents the assembled byte on valid/ready.
// Optional even-parity output enabled by defining REG8FILE_READER_PARITY_EN.
module reg8file_reader #(
   parameter int NREG   = 8,
   parameter int RSEL_W = 3,
   parameter int SETTLE = 1
) (
   input logic                clk,
   input logic                clr,
   reg8file_reader_if.master  bus
);

   localparam int WC_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
   localparam logic [RSEL_W-1:0] LAST_IDX = RSEL_W'(NREG - 1);
   localparam logic [WC_W-1:0]   SETTLE_W = WC_W'(SETTLE);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      VALID = 2'd2
   } state_t;

   state_t            state_r, state_n;
   logic [RSEL_W-1:0] idx_r, idx_n;
   logic [WC_W-1:0]   wcnt_r, wcnt_n;
   logic [NREG-1:0]   asm_r, asm_n;
   logic [NREG-1:0]   data_r, data_n;
`ifdef REG8FILE_READER_PARITY_EN
   logic              parity_r, parity_n;
`endif

   always_ff @(posedge clk) begin
      if (clr) begin
         state_r  <= IDLE;
         idx_r    <= '0;
         wcnt_r   <= '0;
         asm_r    <= '0;
         data_r   <= '0;
`ifdef REG8FILE_READER_PARITY_EN
         parity_r <= 1'b0;
`endif
      end else begin
         state_r  <= state_n;
         idx_r    <= idx_n;
         wcnt_r   <= wcnt_n;
         asm_r    <= asm_n;
         data_r   <= data_n;
`ifdef REG8FILE_READER_PARITY_EN
         parity_r <= parity_n;
`endif
      end
   end

   // idx is parked at 0 outside SCAN, so it doubles as the registered rsel.
   always_comb begin
      state_n  = state_r;
      idx_n    = idx_r;
      wcnt_n   = wcnt_r;
      asm_n    = asm_r;
      data_n   = data_r;
`ifdef REG8FILE_READER_PARITY_EN
      parity_n = parity_r;
`endif
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               state_n = SCAN;
               idx_n   = '0;
               wcnt_n  = '0;
               asm_n   = '0;
            end
         end
         SCAN: begin
            if (wcnt_r < SETTLE_W) begin
               wcnt_n = wcnt_r + WC_W'(1);
            end else begin
               asm_n[idx_r] = bus.q;
               wcnt_n       = '0;
               if (idx_r != LAST_IDX) begin
                  idx_n = idx_r + RSEL_W'(1);
               end else begin
                  data_n  = asm_n;
`ifdef REG8FILE_READER_PARITY_EN
                  parity_n = ^asm_n;
`endif
                  idx_n   = '0;
                  state_n = VALID;
               end
            end
         end
         VALID: begin
            if (bus.ready) begin
               if (bus.start) begin
                  state_n = SCAN;
                  idx_n   = '0;
                  wcnt_n  = '0;
                  asm_n   = '0;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.rsel  = idx_r;
   assign bus.data  = data_r;
   assign bus.valid = (state_r == VALID);
   assign bus.busy  = (state_r == SCAN);
`ifdef REG8FILE_READER_PARITY_EN
   assign bus.parity = parity_r;
`endif

endmodule

// File: tb/tb_reg8file_reader.sv
// Scoreboard bench for reg8file_reader: one instance at SETTLE=1, one at SETTLE=0, sharing a modelled register file.
module tb_reg8file_reader;

   logic       clk;
   logic       clr;
   logic [7:0] rf;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   logic [7:0] sb0[$];
   logic [7:0] sb1[$];

   reg8file_reader_if #(.NREG(8), .RSEL_W(3)) if0 ();
   reg8file_reader_if #(.NREG(8), .RSEL_W(3)) if1 ();

   reg8file_reader #(.NREG(8), .RSEL_W(3), .SETTLE(1)) u0 (.clk(clk), .clr(clr), .bus(if0));
   reg8file_reader #(.NREG(8), .RSEL_W(3), .SETTLE(0)) u1 (.clk(clk), .clr(clr), .bus(if1));

   assign if0.q = rf[if0.rsel];
   assign if1.q = rf[if1.rsel];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor: every completing handshake must match the oldest expected byte.
   always @(negedge clk) begin
      logic [7:0] e;
      if (!clr) begin
         if (if0.valid && if0.ready) begin
            if (sb0.size() == 0) begin
               n_total++;
               $display("FAIL sb0_unexpected: got byte %0h expected none", if0.data);
            end else begin
               e = sb0.pop_front();
               check("sb0_data", 32'(if0.data), 32'(e));
`ifdef REG8FILE_READER_PARITY_EN
               check("sb0_parity", 32'(if0.parity), 32'(^e));
`endif
            end
         end
         if (if1.valid && if1.ready) begin
            if (sb1.size() == 0) begin
               n_total++;
               $display("FAIL sb1_unexpected: got byte %0h expected none", if1.data);
            end else begin
               e = sb1.pop_front();
               check("sb1_data", 32'(if1.data), 32'(e));
            end
         end
      end
   end

   initial begin
      clr = 1'b1;
      rf  = 8'hA5;
      if0.start = 1'b0; if0.ready = 1'b0;
      if1.start = 1'b0; if1.ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 clr = 1'b0;
      @(negedge clk);
      check("rst_rsel",  32'(if0.rsel),  0);
      check("rst_data",  32'(if0.data),  0);
      check("rst_valid", 32'(if0.valid), 0);
      check("rst_busy",  32'(if0.busy),  0);
      check("rst1_valid", 32'(if1.valid), 0);

      // SETTLE=1 scan of 0xA5: rsel 0,0,1,1,..,7,7 then valid on edge 16
      @(posedge clk); #1 if0.start = 1'b1; sb0.push_back(8'hA5);
      @(posedge clk); #1 if0.start = 1'b0;
      @(negedge clk);
      check("s1_busy_k0", 32'(if0.busy), 1);
      check("s1_rsel_k0", 32'(if0.rsel), 0);
      for (int k = 1; k < 16; k++) begin
         @(negedge clk);
         check("s1_busy", 32'(if0.busy), 1);
         check("s1_rsel", 32'(if0.rsel), 32'(k / 2));
      end
      @(negedge clk);
      check("s1_valid", 32'(if0.valid), 1);
      check("s1_busy_done", 32'(if0.busy), 0);
      check("s1_rsel_done", 32'(if0.rsel), 0);
      check("s1_data", 32'(if0.data), 32'h A5);
`ifdef REG8FILE_READER_PARITY_EN
      check("par_a5", 32'(if0.parity), 0);
`endif

      // Stalled consumer: start is ignored while valid waits for ready
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1 if0.start = 1'b1;
         @(negedge clk);
         check("hold_valid", 32'(if0.valid), 1);
         check("hold_busy",  32'(if0.busy),  0);
         check("hold_data",  32'(if0.data),  32'hA5);
      end
      @(posedge clk); #1 if0.start = 1'b0; if0.ready = 1'b1;
      @(posedge clk); #1 if0.ready = 1'b0;
      @(negedge clk);
      check("hs_valid", 32'(if0.valid), 0);
      check("hs_busy",  32'(if0.busy),  0);

      // SETTLE=0: one entry per edge, valid on edge 8
      @(posedge clk); #1 if1.start = 1'b1; sb1.push_back(8'hA5);
      @(posedge clk); #1 if1.start = 1'b0;
      @(negedge clk);
      check("s0_busy_k0", 32'(if1.busy), 1);
      for (int k = 0; k < 8; k++) begin
         if (k > 0) @(negedge clk);
         check("s0_rsel", 32'(if1.rsel), 32'(k));
      end
      @(negedge clk);
      check("s0_valid", 32'(if1.valid), 1);
      check("s0_data",  32'(if1.data),  32'hA5);

      // Back-to-back: new scan accepted on the same edge as the handshake
      @(posedge clk); #1 if0.start = 1'b1; sb0.push_back(8'hA5);
      @(posedge clk); #1 if0.start = 1'b0;
      repeat (17) @(negedge clk);
      check("b2b_first_valid", 32'(if0.valid), 1);
      @(posedge clk); #1 rf = 8'h3C; if0.ready = 1'b1; if0.start = 1'b1; sb0.push_back(8'h3C);
      @(posedge clk); #1 if0.start = 1'b0;
      @(negedge clk);
      check("b2b_busy",  32'(if0.busy),  1);
      check("b2b_valid", 32'(if0.valid), 0);
      check("b2b_old",   32'(if0.data),  32'hA5);
      repeat (15) @(negedge clk);
      check("b2b_old_k15", 32'(if0.data), 32'hA5);
      @(negedge clk);
      check("b2b_valid2", 32'(if0.valid), 1);
      check("b2b_new",    32'(if0.data),  32'h3C);
      @(posedge clk); #1 if0.ready = 1'b0;

      // Abort with clr while idx=4, then a clean full rescan
      rf = 8'h5A; if0.start = 1'b1;
      @(posedge clk); #1 if0.start = 1'b0;
      repeat (9) @(negedge clk);
      check("abort_rsel4", 32'(if0.rsel), 4);
      #1 clr = 1'b1;
      @(posedge clk); #1 clr = 1'b0;
      @(negedge clk);
      check("abort_data",  32'(if0.data),  0);
      check("abort_valid", 32'(if0.valid), 0);
      check("abort_busy",  32'(if0.busy),  0);
      check("abort_rsel",  32'(if0.rsel),  0);
`ifdef REG8FILE_READER_PARITY_EN
      check("par_clr", 32'(if0.parity), 0);
`endif
      @(posedge clk); #1 if0.start = 1'b1; if0.ready = 1'b1; sb0.push_back(8'h5A);
      @(posedge clk); #1 if0.start = 1'b0;
      repeat (16) @(negedge clk);
      check("rescan_busy_k15", 32'(if0.busy), 1);
      check("rescan_nopartial", 32'(if0.data), 0);
      @(negedge clk);
      check("rescan_valid", 32'(if0.valid), 1);
      check("rescan_data",  32'(if0.data),  32'h5A);

`ifdef REG8FILE_READER_PARITY_EN
      @(posedge clk); #1 rf = 8'h07; if0.start = 1'b1; sb0.push_back(8'h07);
      @(posedge clk); #1 if0.start = 1'b0;
      repeat (17) @(negedge clk);
      check("par_07", 32'(if0.parity), 1);
`endif

      @(posedge clk); #1 if0.ready = 1'b0;
      repeat (3) @(negedge clk);
      check("sb0_drained", 32'(sb0.size()), 0);
      check("sb1_drained", 32'(sb1.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
